irq_ctrl: RTL

Interrupt source for the CPU's `irq` input, which the program counter treats as an asynchronous rising edge that vectors fetch to 0x8000_0008. The block does the following:
- Collects up to N_SRC peripheral interrupt lines.
- Edge-detects and latches them as pending, and masks them.
- Selects the highest-priority source.
- Drives one clean, registered `irq` pulse per service, held until the CPU acknowledges.
- Blocks further interrupts until return-from-exception (`eret`).

Software reads the claimed source ID through a small register port.

---
 rtl/irq_pkg.sv | 23 ++
 rtl/irq_ctrl_if.sv | 31 +++
 rtl/irq_prio_enc.sv | 24 ++
 rtl/irq_ctrl.sv | 116 +++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt controller: FSM encoding,
// register map and the ID width helper.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

  localparam logic [1:0] REG_MASK  = 2'd0;
  localparam logic [1:0] REG_PEND  = 2'd1;
  localparam logic [1:0] REG_CLAIM = 2'd2;
  localparam logic [1:0] REG_STAT  = 2'd3;

  localparam int          CLAIM_VALID_BIT = 31;
  localparam logic [31:0] IRQ_VECTOR      = 32'h8000_0008;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// CPU/peripheral-facing bundle of the interrupt controller.
// Handshake: irq is held high until a one-cycle irq_ack; a one-cycle eret ends service.
interface irq_ctrl_if #(
  parameter int N_SRC = 8
) ();
  import irq_pkg::*;

  localparam int ID_W = id_width(N_SRC);

  logic [N_SRC-1:0] src_in;
  logic             irq;
  logic             irq_ack;
  logic             eret;
  logic [1:0]       reg_addr;
  logic             reg_we;
  logic [31:0]      reg_wdata;
  logic [31:0]      reg_rdata;
  logic [ID_W-1:0]  cur_id;
  irq_state_t       state;

  modport master (
    output src_in, irq_ack, eret, reg_addr, reg_we, reg_wdata,
    input  irq, reg_rdata, cur_id, state
  );

  modport slave (
    input  src_in, irq_ack, eret, reg_addr, reg_we, reg_wdata,
    output irq, reg_rdata, cur_id, state
  );

endinterface

// File: rtl/irq_prio_enc.sv
// Combinational priority encoder: the lowest set request index wins.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int N_SRC = 8,
  parameter int ID_W  = id_width(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  output logic [ID_W-1:0]  id,
  output logic             valid
);

  always_comb begin
    id    = '0;
    valid = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        id    = ID_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronizes and edge-detects sources, latches them as
// pending, masks, prioritizes and drives one registered irq per service.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int N_SRC = 8
) (
  input logic       clk,
  input logic       reset,
  irq_ctrl_if.slave bus
);

  localparam int ID_W = id_width(N_SRC);

  logic [N_SRC-1:0] sync1, sync2, prev;
  logic [N_SRC-1:0] rise, w1c, ack_clr, req;
  logic [N_SRC-1:0] mask, pend;
  logic [1:0]       warm_cnt;
  logic             warm;
  logic             ack_take;
  logic [ID_W-1:0]  win_id;
  logic             win_valid;
  irq_state_t       state;
  logic             irq;
  logic [ID_W-1:0]  cur_id;
  logic [31:0]      rdata;

  // Edges are ignored until the sync chain has refilled after reset, so a line
  // held high across reset release is not mistaken for a fresh rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      prev     <= '0;
      warm_cnt <= 2'd0;
    end else begin
      sync1 <= bus.src_in;
      sync2 <= sync1;
      prev  <= sync2;
      if (warm_cnt != 2'd3) warm_cnt <= warm_cnt + 2'd1;
    end
  end

  assign warm     = (warm_cnt == 2'd3);
  assign rise     = warm ? (sync2 & ~prev) : '0;
  assign ack_take = (state == ASSERT) && bus.irq_ack;
  assign w1c      = (bus.reg_we && bus.reg_addr == REG_PEND) ? bus.reg_wdata[N_SRC-1:0] : '0;
  assign ack_clr  = ack_take ? (N_SRC'(1) << cur_id) : '0;
  assign req      = pend & mask;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask <= '0;
      pend <= '0;
    end else begin
      if (bus.reg_we && bus.reg_addr == REG_MASK) mask <= bus.reg_wdata[N_SRC-1:0];
      pend <= (pend & ~(w1c | ack_clr)) | rise;
    end
  end

  irq_prio_enc #(.N_SRC(N_SRC), .ID_W(ID_W)) u_prio_enc (
    .req   (req),
    .id    (win_id),
    .valid (win_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      irq    <= 1'b0;
      cur_id <= '0;
    end else begin
      case (state)
        IDLE: if (win_valid) begin
          state  <= ASSERT;
          irq    <= 1'b1;
          cur_id <= win_id;
        end
        ASSERT: if (bus.irq_ack) begin
          state <= SERVICE;
          irq   <= 1'b0;
        end
        SERVICE: if (bus.eret) begin
          state  <= IDLE;
          cur_id <= '0;
        end
        default: begin
          state <= IDLE;
          irq   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (bus.reg_addr)
      REG_MASK:  rdata[N_SRC-1:0] = mask;
      REG_PEND:  rdata[N_SRC-1:0] = pend;
      REG_CLAIM: begin
        rdata[CLAIM_VALID_BIT] = (state != IDLE);
        rdata[ID_W-1:0]        = cur_id;
      end
      default: begin
        rdata[1:0] = state;
        rdata[2]   = irq;
      end
    endcase
  end

  assign bus.irq       = irq;
  assign bus.cur_id    = cur_id;
  assign bus.state     = state;
  assign bus.reg_rdata = rdata;

endmodule
